// File: rtl/sha_block_loader_if.sv
// sha_block_loader_if: word-stream input, chaining value and wide block output of the block loader.
// Latency: none (wires only).
// Backpressure: word_ready_o / block_ready_i carry flow control in each direction.
interface sha_block_loader_if #(
  parameter int COUNT_WIDTH = 32
) ();

  // serial message word input
  logic [31:0]            word_i;
  logic                   word_valid_i;
  logic                   word_ready_o;

  // chaining value in, sampled with word 0 of each block
  logic [7:0][31:0]       iv_i;

  // wide block output towards the first round stage
  logic [7:0][31:0]       state_o;
  logic [15:0][31:0]      W_o;
  logic                   block_valid_o;
  logic                   block_ready_i;

  // status
  logic [3:0]             word_count_o;
  logic [COUNT_WIDTH-1:0] blocks_issued_o;

  // loader side
  modport slave (
    input  word_i, word_valid_i, iv_i, block_ready_i,
    output word_ready_o, state_o, W_o, block_valid_o, word_count_o, blocks_issued_o
  );

  // producer / pipeline side
  modport master (
    output word_i, word_valid_i, iv_i, block_ready_i,
    input  word_ready_o, state_o, W_o, block_valid_o, word_count_o, blocks_issued_o
  );

endinterface

// File: rtl/sha_block_loader.sv
// sha_block_loader: packs 16 serial message words plus the chaining value into one wide block.
// Latency: block_valid_o rises the cycle after the 16th word is accepted; zero bubble when the output drains on that edge.
// Backpressure: a second complete block parks in the fill buffer and word_ready_o drops until the output register drains.
module sha_block_loader #(
  parameter int BLOCK_WORDS = 16,
  parameter int COUNT_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  sha_block_loader_if.slave bus
);

  // The schedule window is fixed at 16 words by SHA-256 itself.
  if (BLOCK_WORDS != 16) begin : g_bad_block_words
    $error("sha_block_loader: BLOCK_WORDS must be 16");
  end

  // fill side
  logic [3:0]             cnt;
  logic [15:0][31:0]      fill_buf;
  logic [7:0][31:0]       iv_buf;
  logic                   fill_full;

  // output register
  logic [15:0][31:0]      out_w;
  logic [7:0][31:0]       out_state;
  logic                   out_vld;
  logic [COUNT_WIDTH-1:0] issued;

  // handshake decode
  logic                   word_ready;
  logic                   accept;
  logic                   last_word;
  logic                   drain;
  logic                   out_free;
  logic [15:0][31:0]      blk_next;

  // Ready depends only on registered state (and reset), never on block_ready_i.
  assign word_ready = !fill_full && !rst;
  assign accept     = bus.word_valid_i && word_ready;
  assign last_word  = accept && (cnt == 4'd15);
  assign drain      = out_vld && bus.block_ready_i;
  // The output register can take a block if empty or emptying on this edge.
  assign out_free   = !out_vld || drain;

  // Completed window as it would look with the incoming word as W[15].
  always_comb begin
    blk_next     = fill_buf;
    blk_next[15] = bus.word_i;
  end

  // Fill buffer, output register, parking flag and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      fill_buf  <= '0;
      iv_buf    <= '0;
      fill_full <= 1'b0;
      out_w     <= '0;
      out_state <= '0;
      out_vld   <= 1'b0;
      issued    <= '0;
    end else begin
      if (accept) begin
        fill_buf[cnt] <= bus.word_i;
        if (cnt == 4'd0) begin
          iv_buf <= bus.iv_i;
        end
        cnt <= cnt + 4'd1;
      end

      if (drain) begin
        issued <= issued + COUNT_WIDTH'(1);
      end

      if (last_word && out_free) begin
        // Straight through to the output register, no bubble.
        out_w     <= blk_next;
        out_state <= iv_buf;
        out_vld   <= 1'b1;
      end else if (last_word) begin
        // Output still occupied: park the block; fill_buf[15] is written above.
        fill_full <= 1'b1;
      end else if (drain) begin
        if (fill_full) begin
          // Parked block follows immediately; iv_buf is untouched while parked.
          out_w     <= fill_buf;
          out_state <= iv_buf;
          fill_full <= 1'b0;
        end else begin
          out_vld <= 1'b0;
        end
      end
    end
  end

  assign bus.word_ready_o    = word_ready;
  assign bus.W_o             = out_w;
  assign bus.state_o         = out_state;
  assign bus.block_valid_o   = out_vld;
  assign bus.word_count_o    = cnt;
  assign bus.blocks_issued_o = issued;

endmodule

// File: tb/tb_sha_block_loader.sv
// tb_sha_block_loader: directed scenarios plus random traffic against a queue-based block model.
// Latency: model blocks appear the cycle after their 16th accepted word.
// Backpressure: model accepts words only while fewer than two complete blocks are resident.
module tb_sha_block_loader;

  localparam logic [255:0] IV0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV2 = 256'h0123456789abcdef_fedcba9876543210_0badc0de_deadbeef_cafef00d_13579bdf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha_block_loader_if #(.COUNT_WIDTH(32)) bus ();

  sha_block_loader #(.BLOCK_WORDS(16), .COUNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0][31:0] w;
    logic [255:0]      st;
  } blk_t;

  blk_t        mq[$];
  logic [31:0] part_w[16];
  logic [255:0] part_iv;
  int          part_n = 0;
  logic [31:0] m_issued = '0;

  // Resident complete blocks live in mq; a partial block accumulates in part_w.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      part_n   = 0;
      m_issued = '0;
    end else begin
      bit dr;
      bit ac;
      dr = (mq.size() > 0) && bus.block_ready_i;
      ac = bus.word_valid_i && (mq.size() < 2);
      if (dr) begin
        void'(mq.pop_front());
        m_issued = m_issued + 32'd1;
      end
      if (ac) begin
        if (part_n == 0) part_iv = bus.iv_i;
        part_w[part_n] = bus.word_i;
        part_n++;
        if (part_n == 16) begin
          blk_t b;
          for (int i = 0; i < 16; i++) b.w[i] = part_w[i];
          b.st = part_iv;
          mq.push_back(b);
          part_n = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("word_ready", {511'd0, bus.word_ready_o}, {511'd0, (!rst && mq.size() < 2)});
    check("block_valid", {511'd0, bus.block_valid_o}, {511'd0, (mq.size() > 0)});
    check("word_count", {508'd0, bus.word_count_o}, {508'd0, 4'(part_n)});
    check("blocks_issued", {480'd0, bus.blocks_issued_o}, {480'd0, m_issued});
    if (mq.size() > 0) begin
      check("W_o", bus.W_o, mq[0].w);
      check("state_o", {256'd0, bus.state_o}, {256'd0, mq[0].st});
    end
  end

  // Activity monitor for the back-to-back scenario.
  bit mon_en = 1'b0;
  int ready_drops = 0;
  int valid_cycles = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!bus.word_ready_o) ready_drops++;
      if (bus.block_valid_o) valid_cycles++;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [255:0] iv);
    int budget;
    logic r;
    budget = 200;
    bus.word_i       = w;
    bus.iv_i         = iv;
    bus.word_valid_i = 1'b1;
    while (1) begin
      r = bus.word_ready_o;
      @(posedge clk);
      #1;
      if (r) break;
      budget--;
      if (budget == 0) begin
        check("send_timeout", 512'd0, 512'd1);
        break;
      end
    end
    bus.word_valid_i = 1'b0;
  endtask

  logic [15:0][31:0] ew;
  logic [31:0]       base;

  initial begin
    bus.word_i        = '0;
    bus.word_valid_i  = 1'b0;
    bus.iv_i          = '0;
    bus.block_ready_i = 1'b0;
    rst               = 1'b1;

    // reset state
    idle(3);
    check("rst_word_ready", {511'd0, bus.word_ready_o}, 512'd0);
    check("rst_block_valid", {511'd0, bus.block_valid_o}, 512'd0);
    check("rst_W", bus.W_o, 512'd0);
    check("rst_state", {256'd0, bus.state_o}, 512'd0);
    check("rst_count", {508'd0, bus.word_count_o}, 512'd0);
    check("rst_issued", {480'd0, bus.blocks_issued_o}, 512'd0);
    rst = 1'b0;
    idle(2);

    // single block, held by the pipeline
    for (int i = 0; i < 16; i++) send_word(32'(i), IV0);
    check("t1_valid_after_16", {511'd0, bus.block_valid_o}, 512'd1);
    idle(3);
    for (int i = 0; i < 16; i++) ew[i] = 32'(i);
    check("t1_W", bus.W_o, ew);
    check("t1_state", {256'd0, bus.state_o}, {256'd0, IV0});
    bus.block_ready_i = 1'b1;
    idle(1);
    bus.block_ready_i = 1'b0;
    check("t1_valid_drained", {511'd0, bus.block_valid_o}, 512'd0);
    check("t1_issued", {480'd0, bus.blocks_issued_o}, 512'd1);

    // back-to-back with the pipeline always ready
    bus.block_ready_i = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 32; i++) send_word(32'h100 + 32'(i), IV2);
    idle(2);
    mon_en = 1'b0;
    check("t2_ready_drops", 512'(ready_drops), 512'd0);
    check("t2_valid_cycles", 512'(valid_cycles), 512'd2);
    check("t2_issued", {480'd0, bus.blocks_issued_o}, 512'd3);
    bus.block_ready_i = 1'b0;

    // backpressure: two blocks resident
    base = bus.blocks_issued_o;
    for (int i = 0; i < 16; i++) send_word(32'hA0 + 32'(i), IV0);
    for (int i = 0; i < 16; i++) send_word(32'hB0 + 32'(i), IV2);
    check("t3_ready_low", {511'd0, bus.word_ready_o}, 512'd0);
    bus.word_i = 32'hDEAD0000;
    bus.word_valid_i = 1'b1;
    idle(4);
    bus.word_valid_i = 1'b0;
    check("t3_A_W0", {480'd0, bus.W_o[0]}, 512'hA0);
    check("t3_count_held", {508'd0, bus.word_count_o}, 512'd0);
    bus.block_ready_i = 1'b1;
    idle(1);
    check("t3_B_valid", {511'd0, bus.block_valid_o}, 512'd1);
    check("t3_B_W0", {480'd0, bus.W_o[0]}, 512'hB0);
    check("t3_B_state", {256'd0, bus.state_o}, {256'd0, IV2});
    check("t3_ready_back", {511'd0, bus.word_ready_o}, 512'd1);
    idle(1);
    bus.block_ready_i = 1'b0;
    check("t3_issued", {480'd0, bus.blocks_issued_o}, {480'd0, base + 32'd2});

    // gapped input, iv_i changing on non-first words
    for (int i = 0; i < 16; i++) begin
      send_word(32'(i), (i == 0) ? IV2 : {$urandom, $urandom, $urandom, $urandom,
                                          $urandom, $urandom, $urandom, $urandom});
      idle(1);
    end
    for (int i = 0; i < 16; i++) ew[i] = 32'(i);
    check("t4_W", bus.W_o, ew);
    check("t4_state", {256'd0, bus.state_o}, {256'd0, IV2});
    bus.block_ready_i = 1'b1;
    idle(1);
    bus.block_ready_i = 1'b0;

    // reset in the middle of a block
    for (int i = 0; i < 7; i++) send_word(32'hEE + 32'(i), IV0);
    rst = 1'b1;
    idle(1);
    check("t5_count", {508'd0, bus.word_count_o}, 512'd0);
    check("t5_valid", {511'd0, bus.block_valid_o}, 512'd0);
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 16; i++) send_word(32'h10 + 32'(i), IV0);
    check("t5_W0", {480'd0, bus.W_o[0]}, 512'h10);
    check("t5_W15", {480'd0, bus.W_o[15]}, 512'h1F);

    // drain and completion on the same edge
    base = bus.blocks_issued_o;
    for (int i = 0; i < 15; i++) send_word(32'h20 + 32'(i), IV2);
    check("t6_old_still_valid", {480'd0, bus.W_o[0]}, 512'h10);
    bus.block_ready_i = 1'b1;
    send_word(32'h2F, IV0);
    check("t6_valid_cont", {511'd0, bus.block_valid_o}, 512'd1);
    check("t6_new_W0", {480'd0, bus.W_o[0]}, 512'h20);
    check("t6_new_W15", {480'd0, bus.W_o[15]}, 512'h2F);
    check("t6_issued", {480'd0, bus.blocks_issued_o}, {480'd0, base + 32'd1});
    idle(1);
    check("t6_drained", {511'd0, bus.block_valid_o}, 512'd0);
    bus.block_ready_i = 1'b0;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      bus.word_valid_i  = ($urandom_range(9) < 7);
      bus.word_i        = $urandom;
      bus.iv_i          = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
      bus.block_ready_i = (c % 600 < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      rst               = ($urandom_range(699) == 0);
      idle(1);
    end
    rst = 1'b0;
    bus.word_valid_i  = 1'b0;
    bus.block_ready_i = 1'b1;
    idle(40);
    check("end_empty", {511'd0, bus.block_valid_o}, 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
